// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
// Shares the single external SRAM port between the UART loader (index 0),
// the decoder milestones and the VGA reader. Round-robin arbitration with
// burst locking, a one-cycle turnaround between owners, a read-tag pipe that
// strobes read_valid when SRAM_read_data is valid, and a write-protect window
// that guards the source image against being overwritten.
//
//  state   | meaning
//  --------+-----------------------------------------------------------------
//  S_IDLE  | port free, arbitrate among pending requests
//  S_GRANT | grant held by own_q; each cycle with req[own_q] high is a beat
//  S_TURN  | one dead cycle (grant=0, SRAM_we_n=1) before the next owner
module sram_access_arbiter #(
  parameter int                 NUM_REQ      = 3,
  parameter int                 READ_LATENCY = 2,
  parameter int                 MAX_BURST    = 16,
  parameter logic [17:0]        PROTECT_TOP  = 18'd146944,
  parameter logic [NUM_REQ-1:0] PROTECT_MASK = 3'b110
) (
  input  logic                    Clock_50,
  input  logic                    Resetn,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_we_n,
  input  logic [NUM_REQ*18-1:0]   req_address,
  input  logic [NUM_REQ*16-1:0]   req_write_data,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      read_valid,
  output logic [15:0]             read_data,
  input  logic [15:0]             SRAM_read_data,
  output logic [17:0]             SRAM_address,
  output logic [15:0]             SRAM_write_data,
  output logic                    SRAM_we_n,
  output logic                    protect_violation,
  output logic [17:0]             violation_address
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        own_q, own_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        own_next;
  logic                 others_pending;

  logic                 beat;
  logic [17:0]          sel_addr;
  logic [15:0]          sel_wdata;
  logic                 sel_we_n;
  logic                 blocked;
  logic [17:0]          addr_hold_q;
  logic [15:0]          wdata_hold_q;
  logic [NUM_REQ-1:0]   rd_push;
  logic [NUM_REQ-1:0]   rd_pipe_q [READ_LATENCY];
  logic                 viol_q;
  logic [17:0]          viol_addr_q;

  // Round-robin pick: first pending request at or above rr_q, with wrap.
  always_comb begin
    logic [IW-1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_q) + k) % NUM_REQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign own_next       = (own_q == IW'(NUM_REQ - 1)) ? '0 : own_q + IW'(1);
  assign others_pending = |(req & ~grant_q);

  // Next-state logic: burst counting, release and re-arbitration.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d   = own_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_TURN: begin
        cnt_d = '0;
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          own_d   = pick_idx;
          state_d = S_GRANT;
        end else begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!req[own_q]) begin
          grant_d = '0;
          rr_d    = own_next;
          cnt_d   = '0;
          state_d = others_pending ? S_TURN : S_IDLE;
        end else if (cnt_q == CW'(MAX_BURST - 1)) begin
          // Burst limit only forces a handover when someone is waiting.
          cnt_d = '0;
          if (others_pending) begin
            grant_d = '0;
            rr_d    = own_next;
            state_d = S_TURN;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      own_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath mux of the owner onto the SRAM port; outputs hold when no beat.
  always_comb begin
    beat      = |(grant_q & req);
    sel_addr  = req_address[int'(own_q)*18 +: 18];
    sel_wdata = req_write_data[int'(own_q)*16 +: 16];
    sel_we_n  = req_we_n[own_q];
    blocked   = beat && !sel_we_n && PROTECT_MASK[own_q] && (sel_addr < PROTECT_TOP);
    SRAM_address    = beat ? sel_addr  : addr_hold_q;
    SRAM_write_data = beat ? sel_wdata : wdata_hold_q;
    SRAM_we_n       = !(beat && !sel_we_n && !blocked);
    rd_push         = (beat && sel_we_n) ? grant_q : '0;
  end

  // Last driven address/data, plus the sticky protection capture.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      viol_q       <= 1'b0;
      viol_addr_q  <= '0;
    end else begin
      addr_hold_q  <= SRAM_address;
      wdata_hold_q <= SRAM_write_data;
      if (blocked && !viol_q) begin
        viol_q      <= 1'b1;
        viol_addr_q <= sel_addr;
      end
    end
  end

  // Read tag pipe; drains independently of ownership so every read strobes once.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int s = 0; s < READ_LATENCY; s++) rd_pipe_q[s] <= '0;
    end else begin
      rd_pipe_q[0] <= rd_push;
      for (int s = 1; s < READ_LATENCY; s++) rd_pipe_q[s] <= rd_pipe_q[s-1];
    end
  end

  assign grant             = grant_q;
  assign read_valid        = rd_pipe_q[READ_LATENCY-1];
  assign read_data         = SRAM_read_data;
  assign protect_violation = viol_q;
  assign violation_address = viol_addr_q;

endmodule
